// File: rtl/rvc_mem_bridge.sv
// Arbitrates an RVC core's fetch and data ports onto one single-port memory
// with a fixed read latency, one outstanding transaction at a time.
//  state | meaning
//  IDLE  | no transaction outstanding; grant a request this cycle
//  BUSY  | waiting LATENCY cycles for the memory response
module rvc_mem_bridge #(
   parameter int ADDR_W     = 14,
   parameter int LATENCY    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              IReqValid,
   input  logic [31:0]       IReqAddr,
   output logic              IReqReady,
   output logic              IRspValid,
   output logic [31:0]       IRspData,
   input  logic              DReqValid,
   input  logic              DReqWrEn,
   input  logic [3:0]        DReqByteEn,
   input  logic              DReqSignExt,
   input  logic [31:0]       DReqAddr,
   input  logic [31:0]       DReqWrData,
   output logic              DReqReady,
   output logic              DRspValid,
   output logic [31:0]       DRspData,
   output logic              Stall,
   output logic              MemReq,
   output logic              MemWrEn,
   output logic [3:0]        MemByteEn,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWrData,
   input  logic [31:0]       MemRdData
);
   localparam int LAT_W = $clog2(LATENCY + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [STV_W-1:0] starve_q, starve_d;
   logic             fetch_q, fetch_d;
   logic             wr_q, wr_d;
   logic [1:0]       size_q, size_d;
   logic [1:0]       lane_q, lane_d;
   logic             sext_q, sext_d;

   logic             grant_i, grant_d;
   logic [1:0]       size_in, lane_in;
   logic [31:0]      rd_shift, load_data;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{IReqAddr[31:ADDR_W+2], IReqAddr[1:0], DReqAddr[31:ADDR_W+2]};

   // size code: 0 byte, 1 half, 2 word; lane is the byte offset inside the word
   always_comb begin
      size_in = DReqByteEn[3] ? 2'd2 : (DReqByteEn[1] ? 2'd1 : 2'd0);
      case (size_in)
         2'd2:    lane_in = 2'b00;
         2'd1:    lane_in = {DReqAddr[1], 1'b0};
         default: lane_in = DReqAddr[1:0];
      endcase
   end

   always_comb begin
      rd_shift = MemRdData >> {lane_q, 3'b000};
      case (size_q)
         2'd0:    load_data = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
         2'd1:    load_data = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
         default: load_data = rd_shift;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      starve_d  = starve_q;
      fetch_d   = fetch_q;
      wr_d      = wr_q;
      size_d    = size_q;
      lane_d    = lane_q;
      sext_d    = sext_q;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      IReqReady = 1'b0;
      IRspValid = 1'b0;
      IRspData  = '0;
      DReqReady = 1'b0;
      DRspValid = 1'b0;
      DRspData  = '0;
      MemReq    = 1'b0;
      MemWrEn   = 1'b0;
      MemByteEn = '0;
      MemAddr   = '0;
      MemWrData = '0;

      case (state_q)
         IDLE: begin
            // grants are gated by Rst so every output reads 0 while reset is held
            if (!Rst) begin
               if (DReqValid && !(IReqValid && starve_q == STV_W'(STARVE_MAX)))
                  grant_d = 1'b1;
               else if (IReqValid)
                  grant_i = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_d = BUSY;
               lat_d   = LAT_W'(LATENCY);
               fetch_d = grant_i;
               wr_d    = grant_d & DReqWrEn;
               size_d  = grant_d ? size_in : 2'd2;
               lane_d  = grant_d ? lane_in : 2'd0;
               sext_d  = grant_d & DReqSignExt;
               MemReq  = 1'b1;
            end
            if (grant_i) begin
               IReqReady = 1'b1;
               MemAddr   = IReqAddr[ADDR_W+1:2];
               MemByteEn = 4'hF;
            end
            if (grant_d) begin
               DReqReady = 1'b1;
               MemAddr   = DReqAddr[ADDR_W+1:2];
               MemWrEn   = DReqWrEn;
               if (DReqWrEn) begin
                  MemByteEn = DReqByteEn << lane_in;
                  MemWrData = DReqWrData << {lane_in, 3'b000};
               end else begin
                  MemByteEn = 4'hF;
               end
            end
         end
         BUSY: begin
            lat_d = lat_q - LAT_W'(1);
            if (lat_q == LAT_W'(1)) begin
               state_d   = IDLE;
               IRspValid = fetch_q;
               IRspData  = fetch_q ? MemRdData : '0;
               DRspValid = ~fetch_q;
               DRspData  = (!fetch_q && !wr_q) ? load_data : '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!IReqValid || grant_i)
         starve_d = '0;
      else if (grant_d && starve_q != STV_W'(STARVE_MAX))
         starve_d = starve_q + STV_W'(1);

      Stall = !Rst && ((IReqValid && !IReqReady) || (DReqValid && !DReqReady));
   end

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         starve_q <= '0;
         fetch_q  <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= '0;
         lane_q   <= '0;
         sext_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         fetch_q  <= fetch_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         lane_q   <= lane_d;
         sext_q   <= sext_d;
      end
   end
endmodule

// File: tb/tb_rvc_mem_bridge.sv
// Two bridges (LATENCY 1 and 3) share one stimulus stream; every cycle each
// is compared against a transaction-level model, plus directed spot checks.
module tb_rvc_mem_bridge;
   localparam int AW = 14;
   localparam int SM = 4;

   logic        Clock = 1'b0;
   logic        Rst;
   logic        IReqValid, DReqValid, DReqWrEn, DReqSignExt;
   logic [31:0] IReqAddr, DReqAddr, DReqWrData, MemRdData;
   logic [3:0]  DReqByteEn;

   logic        ir_rdy[2], irsp_v[2], dr_rdy[2], drsp_v[2], stall[2], mreq[2], mwe[2];
   logic [31:0] irsp_d[2], drsp_d[2], mwd[2];
   logic [3:0]  mbe[2];
   logic [AW-1:0] maddr[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      rvc_mem_bridge #(.ADDR_W(AW), .LATENCY(g == 0 ? 1 : 3), .STARVE_MAX(SM)) u_dut (
         .Clock(Clock), .Rst(Rst),
         .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(ir_rdy[g]),
         .IRspValid(irsp_v[g]), .IRspData(irsp_d[g]),
         .DReqValid(DReqValid), .DReqWrEn(DReqWrEn), .DReqByteEn(DReqByteEn),
         .DReqSignExt(DReqSignExt), .DReqAddr(DReqAddr), .DReqWrData(DReqWrData),
         .DReqReady(dr_rdy[g]), .DRspValid(drsp_v[g]), .DRspData(drsp_d[g]),
         .Stall(stall[g]), .MemReq(mreq[g]), .MemWrEn(mwe[g]), .MemByteEn(mbe[g]),
         .MemAddr(maddr[g]), .MemWrData(mwd[g]), .MemRdData(MemRdData));
   end

   always #5 Clock = ~Clock;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int lat_of[2] = '{1, 3};

   // model: a transaction granted in cycle T answers in cycle T+LATENCY
   int   resp_cyc[2] = '{-1, -1};
   int   starve[2]   = '{0, 0};
   int   c_size[2], c_lane[2];
   bit   c_fetch[2], c_wr[2], c_sext[2];
   bit   gi[2], gd[2];
   logic [120:0] expv[2];

   function automatic logic [120:0] pack(input logic ir, input logic iv, input logic [31:0] id,
                                         input logic dr, input logic dv, input logic [31:0] dd,
                                         input logic st, input logic mq, input logic mw,
                                         input logic [3:0] mb, input logic [AW-1:0] ma,
                                         input logic [31:0] md);
      return {ir, iv, id, dr, dv, dd, st, mq, mw, mb, ma, md};
   endfunction

   function automatic logic [31:0] load_result(input logic [31:0] rd, input int sz,
                                               input int ln, input bit sx);
      longint unsigned v, m;
      v = longint'(rd >> (8 * ln));
      m = (longint'(1) << (8 * sz)) - 1;
      v = v & m;
      if (sx && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~m;
      return 32'(v);
   endfunction

   function automatic int size_of(input logic [3:0] be);
      return (be == 4'b1111) ? 4 : (be == 4'b0011) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic model_eval(input int k);
      logic ir, iv, dr, dv, st, mq, mw;
      logic [31:0] id, dd, md;
      logic [3:0] mb;
      logic [AW-1:0] ma;
      int sz, ln;
      {ir, iv, dr, dv, st, mq, mw} = '0;
      id = '0; dd = '0; md = '0; mb = '0; ma = '0;
      gi[k] = 1'b0;
      gd[k] = 1'b0;
      if (!Rst) begin
         if (cyc <= resp_cyc[k]) begin
            if (cyc == resp_cyc[k]) begin
               if (c_fetch[k]) begin
                  iv = 1'b1;
                  id = MemRdData;
               end else begin
                  dv = 1'b1;
                  if (!c_wr[k]) dd = load_result(MemRdData, c_size[k], c_lane[k], c_sext[k]);
               end
            end
         end else begin
            gd[k] = DReqValid && !(IReqValid && starve[k] == SM);
            gi[k] = IReqValid && !gd[k];
         end
         ir = gi[k];
         dr = gd[k];
         st = (IReqValid && !ir) || (DReqValid && !dr);
         if (gi[k]) begin
            mq = 1'b1;
            ma = IReqAddr[AW+1:2];
            mb = 4'hF;
         end
         if (gd[k]) begin
            mq = 1'b1;
            mw = DReqWrEn;
            ma = DReqAddr[AW+1:2];
            sz = size_of(DReqByteEn);
            ln = int'(DReqAddr[1:0]) & ~(sz - 1);
            if (DReqWrEn) begin
               mb = 4'(((1 << sz) - 1) << ln);
               md = DReqWrData << (8 * ln);
            end else begin
               mb = 4'hF;
            end
         end
      end
      expv[k] = pack(ir, iv, id, dr, dv, dd, st, mq, mw, mb, ma, md);
   endtask

   task automatic model_update(input int k);
      if (Rst) begin
         resp_cyc[k] = -1;
         starve[k]   = 0;
      end else begin
         if (gi[k] || gd[k]) begin
            resp_cyc[k] = cyc + lat_of[k];
            c_fetch[k]  = gi[k];
            c_wr[k]     = gd[k] && DReqWrEn;
            c_size[k]   = size_of(DReqByteEn);
            c_lane[k]   = int'(DReqAddr[1:0]) & ~(c_size[k] - 1);
            c_sext[k]   = DReqSignExt;
         end
         if (!IReqValid || gi[k]) starve[k] = 0;
         else if (gd[k] && starve[k] < SM) starve[k]++;
      end
   endtask

   task automatic sample();
      @(negedge Clock);
      for (int k = 0; k < 2; k++) begin
         model_eval(k);
         chk($sformatf("L%0d_cyc%0d", lat_of[k], cyc),
             pack(ir_rdy[k], irsp_v[k], irsp_d[k], dr_rdy[k], drsp_v[k], drsp_d[k],
                  stall[k], mreq[k], mwe[k], mbe[k], maddr[k], mwd[k]), expv[k]);
      end
   endtask

   task automatic advance();
      @(posedge Clock);
      for (int k = 0; k < 2; k++) model_update(k);
      cyc++;
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic idle_in();
      IReqValid = 0; IReqAddr = '0; DReqValid = 0; DReqWrEn = 0; DReqByteEn = 4'hF;
      DReqSignExt = 0; DReqAddr = '0; DReqWrData = '0;
   endtask

   task automatic drain();
      idle_in();
      for (int i = 0; i < 4; i++) tick();
   endtask

   logic [5:0] seq[2];
   int gcnt[2];

   initial begin
      Rst = 1'b1;
      idle_in();
      MemRdData = 32'h0;
      tick();
      IReqValid = 1; DReqValid = 1;
      sample();
      chk("reset_stall", stall[1], 1'b0);
      chk("reset_memreq", mreq[1], 1'b0);
      advance();

      // fetch at 0x10, first cycle out of reset
      Rst = 0; idle_in();
      IReqValid = 1; IReqAddr = 32'h10;
      sample();
      chk("fetch_memreq", mreq[0], 1'b1);
      chk("fetch_memaddr", maddr[0], 14'd4);
      chk("fetch_ready", ir_rdy[0], 1'b1);
      advance();
      IReqValid = 0; MemRdData = 32'hCAFE_F00D;
      sample();
      chk("fetch_rsp_valid", irsp_v[0], 1'b1);
      chk("fetch_rsp_data", irsp_d[0], 32'hCAFE_F00D);
      advance();
      IReqValid = 1; IReqAddr = 32'h20;
      sample();
      chk("fetch_next_grant", ir_rdy[0], 1'b1);
      advance();
      drain();

      // signed byte load from lane 3
      DReqValid = 1; DReqByteEn = 4'b0001; DReqSignExt = 1; DReqAddr = 32'h103;
      sample();
      chk("ldb_ready", dr_rdy[1], 1'b1);
      chk("ldb_byteen", mbe[1], 4'hF);
      advance();
      idle_in();
      tick();
      tick();
      MemRdData = 32'h80AB_CDEF;
      sample();
      chk("ldb_rsp_valid", drsp_v[1], 1'b1);
      chk("ldb_rsp_data", drsp_d[1], 32'hFFFF_FF80);
      advance();
      drain();

      // halfword store to lane 2
      DReqValid = 1; DReqWrEn = 1; DReqByteEn = 4'b0011; DReqAddr = 32'h22; DReqWrData = 32'h1234;
      sample();
      chk("sth_byteen", mbe[0], 4'b1100);
      chk("sth_wrdata", mwd[0], 32'h1234_0000);
      chk("sth_wren", mwe[0], 1'b1);
      advance();
      idle_in();
      sample();
      chk("sth_rsp_l1", {drsp_v[0], drsp_d[0]}, {1'b1, 32'h0});
      advance();
      tick();
      sample();
      chk("sth_rsp_l3", {drsp_v[1], drsp_d[1]}, {1'b1, 32'h0});
      advance();
      drain();

      // both requesters held high: data x4, fetch, data
      IReqValid = 1; IReqAddr = 32'h400; DReqValid = 1; DReqAddr = 32'h800;
      seq = '{6'b0, 6'b0};
      gcnt = '{0, 0};
      sample();
      chk("both_valid_dready", dr_rdy[0], 1'b1);
      chk("both_valid_iready", ir_rdy[0], 1'b0);
      for (int c = 0; c < 24; c++) begin
         if (c != 0) sample();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("starve_stall_L%0d_c%0d", lat_of[k], c), stall[k], 1'b1);
            if ((ir_rdy[k] || dr_rdy[k]) && gcnt[k] < 6) begin
               seq[k][gcnt[k]] = ir_rdy[k];
               gcnt[k]++;
            end
         end
         advance();
      end
      chk("starve_seq_L1", seq[0], 6'b010000);
      chk("starve_seq_L3", seq[1], 6'b010000);
      drain();

      // reset one cycle into a LATENCY=3 load
      DReqValid = 1; DReqByteEn = 4'hF; DReqAddr = 32'h40;
      sample();
      chk("rst_load_grant", dr_rdy[1], 1'b1);
      advance();
      DReqValid = 0; IReqValid = 1; IReqAddr = 32'h80;
      #2 Rst = 1;
      sample();
      chk("rst_outputs_zero",
          pack(ir_rdy[1], irsp_v[1], irsp_d[1], dr_rdy[1], drsp_v[1], drsp_d[1],
               stall[1], mreq[1], mwe[1], mbe[1], maddr[1], mwd[1]), '0);
      advance();
      Rst = 0;
      sample();
      chk("grant_after_rst", ir_rdy[1], 1'b1);
      advance();
      IReqValid = 0;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk($sformatf("no_drsp_after_rst_%0d", i), drsp_v[1], 1'b0);
         advance();
      end

      // random traffic, occasional reset
      for (int i = 0; i < 400; i++) begin
         Rst         = ($urandom_range(0, 63) == 0);
         IReqValid   = ($urandom_range(0, 3) != 0);
         IReqAddr    = $urandom;
         DReqValid   = ($urandom_range(0, 3) != 0);
         DReqWrEn    = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       DReqByteEn = 4'b0001;
            1:       DReqByteEn = 4'b0011;
            default: DReqByteEn = 4'b1111;
         endcase
         DReqSignExt = 1'($urandom_range(0, 1));
         DReqAddr    = $urandom;
         DReqWrData  = $urandom;
         MemRdData   = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rvc_mem_bridge.md
RVC_MEM_BRIDGE -- requirements
Module: rvc_mem_bridge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 14, memory word-address width.
- LATENCY, 1, cycles from MemReq to MemRdData valid; legal range 1..8.
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits.

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clock, in, 1, single clock, rising edge.
- Rst, in, 1, asynchronous, active-high reset.
- IReqValid, in, 1, fetch request.
- IReqAddr, in, 32, fetch byte address.
- IReqReady, out, 1, fetch accepted this cycle.
- IRspValid, out, 1, fetch data valid.
- IRspData, out, 32, fetched instruction.
- DReqValid, in, 1, data request.
- DReqWrEn, in, 1, 1 = store, 0 = load.
- DReqByteEn, in, 4, size code: 0001 byte, 0011 half, 1111 word.
- DReqSignExt, in, 1, sign-extend load result.
- DReqAddr, in, 32, data byte address.
- DReqWrData, in, 32, store data, LSB-aligned.
- DReqReady, out, 1, data request accepted this cycle.
- DRspValid, out, 1, data transaction complete.
- DRspData, out, 32, extended load data.
- Stall, out, 1, core must hold its request.
- MemReq, out, 1, memory access strobe.
- MemWrEn, out, 1, memory write.
- MemByteEn, out, 4, lane enables.
- MemAddr, out, ADDR_W, word address.
- MemWrData, out, 32, lane-aligned write data.
- MemRdData, in, 32, read data, valid LATENCY cycles after MemReq.

Function
REQ-003 The FSM SHALL have states IDLE and BUSY, with one outstanding memory transaction at most.

REQ-004 In IDLE, a request SHALL be granted in the same cycle: data wins, unless IReqValid is 1 and the starve counter equals STARVE_MAX, in which case the fetch wins.

REQ-005 The granted Ready output SHALL be 1 only in the grant cycle; both Ready outputs SHALL be 0 in BUSY.

REQ-006 In the grant cycle T, the bridge SHALL drive the memory bus combinationally, go to BUSY, and load the latency counter with LATENCY:
- MemReq = 1.
- MemAddr = Addr[ADDR_W+1:2].
- MemWrEn = DReqWrEn for data grants, 0 for fetches.

REQ-007 The latency counter SHALL decrement each BUSY cycle; the response cycle is T+LATENCY, after which the FSM returns to IDLE, so the earliest next grant is T+LATENCY+1.

REQ-008 In cycle T+LATENCY the response SHALL be presented for exactly one cycle:
- Fetch: IRspValid = 1, IRspData = MemRdData.
- Data: DRspValid = 1.

REQ-009 Stores SHALL shift both MemByteEn and MemWrData left by lane (DReqAddr[1:0] × 8 bits for data):
- Byte lane = addr[1:0].
- Half lane = {addr[1], 0}.
- Word lane = 0.

REQ-010 Loads SHALL drive MemByteEn = 1111; the size, lane and SignExt SHALL be captured at grant.

REQ-011 At T+LATENCY, DRspData SHALL be the captured lane of MemRdData, sign-extended if SignExt = 1, else zero-extended; stores SHALL return DRspData = 0.

REQ-012 The starve counter SHALL track data grants made while IReqValid was 1:
- Increment on each such data grant, saturating at STARVE_MAX.
- Clear on any fetch grant.
- Clear on any cycle with IReqValid = 0.

REQ-013 Stall SHALL be (IReqValid & ~IReqReady) | (DReqValid & ~DReqReady).

REQ-014 When both IReqValid and DReqValid are 1 in IDLE, exactly one SHALL be granted; the other SHALL see Ready = 0.

REQ-015 Requests whose Valid drops before grant SHALL be dropped without any memory access.

REQ-016 All Mem* outputs SHALL be 0 in every cycle without a grant.

Reset
REQ-017 On Rst = 1 the bridge SHALL immediately (asynchronously) set:
- State IDLE, latency counter 0, starve counter 0, captured load info 0.
- All outputs 0.

REQ-018 A transaction in flight at reset SHALL be abandoned; no response SHALL be produced after Rst deasserts.

REQ-019 The first grant SHALL be possible in the first cycle with Rst = 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- LATENCY = 1, fetch only, addr 0x10 -> MemReq with MemAddr = 4 in T; IRspValid in T+1 with IRspData = MemRdData; next grant at T+2.
- LATENCY = 3, load byte, addr 0x...3, SignExt = 1, MemRdData = 0x80xxxxxx -> DRspData = 0xFFFFFF80 at T+3.
- Store half, addr 0x...2, data 0x1234 -> MemByteEn = 1100, MemWrData = 0x12340000, DRspValid at T+LATENCY with DRspData = 0.
- STARVE_MAX = 4, IReqValid and DReqValid both held high -> 4 data grants, then 1 fetch grant, then data again; Stall = 1 throughout.
- Rst pulsed in cycle T+1 of a LATENCY = 3 load -> all outputs 0 immediately; no DRspValid afterwards; new grant in the first cycle after release.
- Both Valid high in IDLE, starve counter 0 -> only DReqReady = 1; IReqReady = 0.
